// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues credit-limited in-order imem requests and buffers
// epoch-tagged responses for decode. Define FETCH_REDIRECT_SQUASH_EN to flush the buffer on redirect.
module fetch_sequencer #(
    parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
    parameter int unsigned DEPTH         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [3:0]  inst_tag,
    output logic        err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;

    state_e        state_q;
    logic [31:0]   pc_q;
    logic [3:0]    tag_q;
    logic          err_q;

    logic [31:0]   fl_pc_q  [DEPTH];
    logic [3:0]    fl_tag_q [DEPTH];
    logic [PW-1:0] fl_wr_q, fl_rd_q;
    logic [CW-1:0] inflight_q, inflight_d;

    logic [31:0]   buf_data_q [DEPTH];
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [3:0]    buf_tag_q  [DEPTH];
    logic [PW-1:0] buf_wr_q, buf_rd_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] total_d;

    logic issue, resp, accept, pop, err_set;

    assign imem_req   = (state_q == StRun) && !redirect;
    assign imem_addr  = pc_q;
    assign issue      = imem_req && imem_gnt;
    assign resp       = imem_rvalid && (inflight_q != '0);
    assign err_set    = imem_rvalid && (inflight_q == '0);
    // Responses from a superseded epoch, or arriving during a redirect, only release their credit.
    assign accept     = resp && (fl_tag_q[fl_rd_q] == tag_q) && !redirect;
    assign inst_valid = count_q != '0;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = buf_data_q[buf_rd_q];
    assign inst_pc    = buf_pc_q[buf_rd_q];
    assign inst_tag   = buf_tag_q[buf_rd_q];
    assign err        = err_q;

    always_comb begin
        inflight_d = inflight_q + CW'(issue) - CW'(resp);
`ifdef FETCH_REDIRECT_SQUASH_EN
        count_d = redirect ? '0 : count_q + CW'(accept) - CW'(pop);
`else
        count_d = count_q + CW'(accept) - CW'(pop);
`endif
        total_d = inflight_d + count_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StBoot;
            pc_q    <= START_ADDRESS;
            tag_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StBoot:  state_q <= StRun;
                default: state_q <= (total_d == DEPTH_C) ? StStall : StRun;
            endcase
            if (redirect) begin
                pc_q  <= redirect_pc & ~32'h3;
                tag_q <= tag_q + 4'd1;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fl_pc_q[i]    <= '0;
                fl_tag_q[i]   <= '0;
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
                buf_tag_q[i]  <= '0;
            end
            fl_wr_q    <= '0;
            fl_rd_q    <= '0;
            inflight_q <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            count_q    <= '0;
        end else begin
            if (issue) begin
                fl_pc_q[fl_wr_q]  <= pc_q;
                fl_tag_q[fl_wr_q] <= tag_q;
                fl_wr_q           <= fl_wr_q + PW'(1);
            end
            if (resp) fl_rd_q <= fl_rd_q + PW'(1);
            inflight_q <= inflight_d;

            if (accept) begin
                buf_data_q[buf_wr_q] <= imem_rdata;
                buf_pc_q[buf_wr_q]   <= fl_pc_q[fl_rd_q];
                buf_tag_q[buf_wr_q]  <= fl_tag_q[fl_rd_q];
                buf_wr_q             <= buf_wr_q + PW'(1);
            end
`ifdef FETCH_REDIRECT_SQUASH_EN
            if (redirect) buf_rd_q <= buf_wr_q;
            else if (pop) buf_rd_q <= buf_rd_q + PW'(1);
`else
            if (pop) buf_rd_q <= buf_rd_q + PW'(1);
`endif
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a fixed-latency in-order memory model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [3:0]  inst_tag;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int lat = 2;
    bit mem_en = 1'b1;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] gl_addr[$];
    logic [31:0] dl_data[$];
    logic [31:0] dl_pc[$];
    logic [3:0]  dl_tag[$];

    fetch_sequencer #(
        .START_ADDRESS(32'h0000_0000),
        .DEPTH        (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_tag   (inst_tag),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Logs grants/deliveries of the current cycle, crosses one edge, then drives the response.
    task automatic tick();
        #1;
        if (imem_req && imem_gnt) begin
            gl_addr.push_back(imem_addr);
            if (mem_en) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + lat);
            end
        end
        if (inst_valid && inst_ready) begin
            dl_data.push_back(inst_data);
            dl_pc.push_back(inst_pc);
            dl_tag.push_back(inst_tag);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mem_en && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hC0DE_0000 ^ pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    endtask

    task automatic clear_logs();
        pend_addr.delete();
        pend_due.delete();
        gl_addr.delete();
        dl_data.delete();
        dl_pc.delete();
        dl_tag.delete();
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        mem_en      = 1'b1;
        lat         = 2;
        clear_logs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_credit_stall();
        apply_reset();
        imem_gnt = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        #1;
        tests_run++;
        if (gl_addr.size() !== 4) begin
            tests_failed++;
            $display("FAIL stall_grants: got %0d grants, expected 4", gl_addr.size());
        end
        tests_run++;
        if (gl_addr.size() == 4 && gl_addr[3] !== 32'hC) begin
            tests_failed++;
            $display("FAIL stall_last_addr: got %h expected 0000000c", gl_addr[3]);
        end
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_req: got %b expected 0", imem_req);
        end
        tests_run++;
        if (inst_valid !== 1'b1 || inst_data !== 32'hC0DE_0000 || inst_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL stall_head: got v=%b d=%h pc=%h expected v=1 d=c0de0000 pc=0",
                     inst_valid, inst_data, inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        #1;
        tests_run++;
        if (gl_addr.size() !== 5 || gl_addr[gl_addr.size()-1] !== 32'h10) begin
            tests_failed++;
            $display("FAIL stall_release: got %0d grants, last %h expected 5 grants, last 00000010",
                     gl_addr.size(), gl_addr[gl_addr.size()-1]);
        end
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_req_again: got %b expected 0", imem_req);
        end
    endtask

    // Entered with a full buffer, so this also covers reset mid-operation.
    task automatic test_reset();
        reset      = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b0;
        redirect   = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got req=%b addr=%h v=%b expected 0/00000000/0",
                     imem_req, imem_addr, inst_valid);
        end
        tests_run++;
        if (inst_data !== 32'h0 || inst_pc !== 32'h0 || inst_tag !== 4'h0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got d=%h pc=%h tag=%h err=%b expected all 0",
                     inst_data, inst_pc, inst_tag, err);
        end
        clear_logs();
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (c == 0) begin
                tests_run++;
                if (imem_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL boot_req: got %b expected 0", imem_req);
                end
            end else begin
                tests_run++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (c - 1))) begin
                    tests_failed++;
                    $display("FAIL boot_issue%0d: got req=%b addr=%h expected 1/%h",
                             c, imem_req, imem_addr, 32'(4 * (c - 1)));
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        lat        = 1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        tests_run++;
        if (gl_addr.size() !== 19) begin
            tests_failed++;
            $display("FAIL b2b_grants: got %0d expected 19", gl_addr.size());
        end
        tests_run++;
        if (dl_pc.size() !== 17) begin
            tests_failed++;
            $display("FAIL b2b_delivered: got %0d expected 17", dl_pc.size());
        end
        for (int i = 0; i < dl_pc.size(); i++) begin
            tests_run++;
            if (dl_pc[i] !== 32'(4 * i) || dl_data[i] !== (32'hC0DE_0000 ^ 32'(4 * i))
                || dl_tag[i] !== 4'h0) begin
                tests_failed++;
                $display("FAIL b2b_inst%0d: got pc=%h d=%h tag=%h expected pc=%h d=%h tag=0",
                         i, dl_pc[i], dl_data[i], dl_tag[i], 32'(4 * i),
                         32'hC0DE_0000 ^ 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        int exp_n;
        apply_reset();
        lat = 3;
        for (int c = 0; c < 16; c++) begin
            imem_gnt    = (c >= 1 && c <= 3) || c == 6 || c == 7;
            redirect    = (c == 5);
            redirect_pc = 32'h103;
            inst_ready  = (c >= 8);
            #1;
            if (c == 5) begin
                tests_run++;
                if (imem_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL redir_req_low: got %b expected 0", imem_req);
                end
            end
            if (c == 6) begin
                tests_run++;
                if (imem_addr !== 32'h100) begin
                    tests_failed++;
                    $display("FAIL redir_addr: got %h expected 00000100", imem_addr);
                end
`ifdef FETCH_REDIRECT_SQUASH_EN
                tests_run++;
                if (inst_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL redir_flush: got valid=%b expected 0", inst_valid);
                end
`else
                tests_run++;
                if (inst_valid !== 1'b1 || inst_tag !== 4'h0 || inst_pc !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL redir_keep: got v=%b tag=%h pc=%h expected 1/0/00000000",
                             inst_valid, inst_tag, inst_pc);
                end
`endif
            end
            tick();
        end
        redirect = 1'b0;
`ifdef FETCH_REDIRECT_SQUASH_EN
        exp_n = 2;
`else
        exp_n = 3;
`endif
        tests_run++;
        if (dl_pc.size() !== exp_n) begin
            tests_failed++;
            $display("FAIL redir_count: got %0d expected %0d", dl_pc.size(), exp_n);
        end
        if (dl_pc.size() >= 2) begin
            tests_run++;
            if (dl_pc[exp_n-2] !== 32'h100 || dl_tag[exp_n-2] !== 4'h1
                || dl_data[exp_n-2] !== 32'hC0DE_0100) begin
                tests_failed++;
                $display("FAIL redir_new0: got pc=%h tag=%h d=%h expected 00000100/1/c0de0100",
                         dl_pc[exp_n-2], dl_tag[exp_n-2], dl_data[exp_n-2]);
            end
            tests_run++;
            if (dl_pc[exp_n-1] !== 32'h104 || dl_tag[exp_n-1] !== 4'h1) begin
                tests_failed++;
                $display("FAIL redir_new1: got pc=%h tag=%h expected 00000104/1",
                         dl_pc[exp_n-1], dl_tag[exp_n-1]);
            end
        end
    endtask

    task automatic test_redirect_response();
        apply_reset();
        lat = 2;
        for (int c = 0; c < 8; c++) begin
            imem_gnt    = (c == 1) || (c == 4);
            redirect    = (c == 3);
            redirect_pc = 32'h40;
            #1;
            if (c == 3) begin
                tests_run++;
                if (imem_rvalid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL simul_setup: got rvalid=%b expected 1", imem_rvalid);
                end
            end
            if (c == 4) begin
                tests_run++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL simul_drop: got req=%b addr=%h v=%b expected 1/00000040/0",
                             imem_req, imem_addr, inst_valid);
                end
            end
            if (c == 7) begin
                tests_run++;
                if (inst_valid !== 1'b1 || inst_tag !== 4'h1 || inst_pc !== 32'h40
                    || inst_data !== 32'hC0DE_0040 || err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL simul_next: got v=%b tag=%h pc=%h d=%h err=%b expected 1/1/00000040/c0de0040/0",
                             inst_valid, inst_tag, inst_pc, inst_data, err);
                end
            end
            tick();
        end
        redirect = 1'b0;
    endtask

    task automatic test_tag_wrap();
        apply_reset();
        lat = 2;
        for (int c = 0; c < 21; c++) begin
            redirect    = (c >= 1 && c <= 16);
            redirect_pc = 32'h200;
            imem_gnt    = (c == 17);
            #1;
            if (c == 17) begin
                tests_run++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
                    tests_failed++;
                    $display("FAIL wrap_issue: got req=%b addr=%h expected 1/00000200",
                             imem_req, imem_addr);
                end
            end
            if (c == 20) begin
                tests_run++;
                if (inst_valid !== 1'b1 || inst_tag !== 4'h0 || inst_pc !== 32'h200) begin
                    tests_failed++;
                    $display("FAIL wrap_tag: got v=%b tag=%h pc=%h expected 1/0/00000200",
                             inst_valid, inst_tag, inst_pc);
                end
            end
            tick();
        end
    endtask

    task automatic test_protocol_error();
        apply_reset();
        mem_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end
            #1;
            if (c == 1) begin
                tests_run++;
                if (err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL err_before: got %b expected 0", err);
                end
            end
            if (c >= 3) begin
                tests_run++;
                if (err !== 1'b1 || inst_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL err_sticky%0d: got err=%b v=%b expected 1/0", c, err, inst_valid);
                end
            end
            tick();
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_reset: got %b expected 0", err);
        end
    endtask

    initial begin
        test_credit_stall();
        test_reset();
        test_back_to_back();
        test_redirect();
        test_redirect_response();
        test_tag_wrap();
        test_protocol_error();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
